// File: rtl/npc_gen_pkg.sv
// Shared front-end types for next-PC generation: reset vector, FSM state
// encoding and the fetch request payload handed to the instruction cache.
package npc_gen_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  typedef enum logic [0:0] {
    RUN,
    PEND
  } npc_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pair;
    logic [1:0]  pred_taken;
    logic [31:0] pred_target;
    logic        epoch;
  } fetch_req_t;

endpackage

// File: rtl/npc_gen_if.sv
// Signal bundle between the next-PC stage and its neighbours: redirects,
// branch predictor, IF queue back-pressure and the I-cache request channel.
interface npc_gen_if;

  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_mistaken;
  logic [31:0] right_target;
  logic [31:0] fetch_pc_0;
  logic [31:0] fetch_pc_1;
  logic        dual_issue;
  logic        taken_0;
  logic        taken_1;
  logic [31:0] ret_pc_0;
  logic [31:0] ret_pc_1;
  logic        ifq_full;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        req_pair;
  logic [1:0]  req_pred_taken;
  logic [31:0] req_pred_target;
  logic        req_epoch;
  logic        cur_epoch;

  modport master (
    input  flush, flush_pc, branch_mistaken, right_target,
    input  taken_0, taken_1, ret_pc_0, ret_pc_1,
    input  ifq_full, req_ready,
    output fetch_pc_0, fetch_pc_1, dual_issue,
    output req_valid, req_pc, req_pair, req_pred_taken, req_pred_target,
    output req_epoch, cur_epoch
  );

  modport slave (
    output flush, flush_pc, branch_mistaken, right_target,
    output taken_0, taken_1, ret_pc_0, ret_pc_1,
    output ifq_full, req_ready,
    input  fetch_pc_0, fetch_pc_1, dual_issue,
    input  req_valid, req_pc, req_pair, req_pred_taken, req_pred_target,
    input  req_epoch, cur_epoch
  );

endinterface

// File: rtl/npc_gen_sel.sv
// npc_sel: combinational prediction and redirect priority mux. Slot 0 beats
// slot 1, slot 1 only counts when the pair is dual, flush beats mispredict.
import npc_gen_pkg::*;

module npc_gen_sel (
  input  logic [31:0] pc_i,
  input  logic        taken_0_i,
  input  logic        taken_1_i,
  input  logic [31:0] ret_pc_0_i,
  input  logic [31:0] ret_pc_1_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_mistaken_i,
  input  logic [31:0] right_target_i,
  output logic [31:0] fetch_pc_1_o,
  output logic        dual_issue_o,
  output logic [31:0] npc_o,
  output logic [1:0]  pred_taken_o,
  output logic        redir_o,
  output logic [31:0] redir_pc_o
);

  always_comb begin
    fetch_pc_1_o = pc_i + 32'd4;
    dual_issue_o = ~pc_i[2];
    redir_o      = flush_i | branch_mistaken_i;
    redir_pc_o   = flush_i ? flush_pc_i : right_target_i;
    // Fall-through jumps to the next 8-byte pair; the 29-bit add wraps at 2^32.
    npc_o        = {pc_i[31:3] + 29'd1, 3'b000};
    pred_taken_o = 2'b00;
    if (taken_0_i) begin
      npc_o        = ret_pc_0_i;
      pred_taken_o = 2'b01;
    end else if (dual_issue_o && taken_1_i) begin
      npc_o        = ret_pc_1_i;
      pred_taken_o = 2'b10;
    end
  end

endmodule

// File: rtl/npc_gen.sv
// Next-PC stage: owns the fetch PC, redirect epoch and the request handshake.
// A redirect arriving while a request is held parks its target in pend_pc.
import npc_gen_pkg::*;

module npc_gen (
  input  logic       clk,
  input  logic       reset,
  npc_gen_if.master  bus
);

  npc_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        epoch_q, epoch_d;
  logic        req_hold_q, req_hold_d;
  logic        held_epoch_q, held_epoch_d;

  logic [31:0] npc, redir_pc, fetch_pc_1;
  logic [1:0]  pred_taken;
  logic        dual_issue, redir;
  logic        req_valid, accept;
  fetch_req_t  req;

  npc_gen_sel u_sel (
    .pc_i              (pc_q),
    .taken_0_i         (bus.taken_0),
    .taken_1_i         (bus.taken_1),
    .ret_pc_0_i        (bus.ret_pc_0),
    .ret_pc_1_i        (bus.ret_pc_1),
    .flush_i           (bus.flush),
    .flush_pc_i        (bus.flush_pc),
    .branch_mistaken_i (bus.branch_mistaken),
    .right_target_i    (bus.right_target),
    .fetch_pc_1_o      (fetch_pc_1),
    .dual_issue_o      (dual_issue),
    .npc_o             (npc),
    .pred_taken_o      (pred_taken),
    .redir_o           (redir),
    .redir_pc_o        (redir_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0;
      epoch_q      <= 1'b0;
      req_hold_q   <= 1'b0;
      held_epoch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      epoch_q      <= epoch_d;
      req_hold_q   <= req_hold_d;
      held_epoch_q <= held_epoch_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    epoch_d      = epoch_q;
    req_hold_d   = req_hold_q;
    // The epoch a request was issued with survives redirects while it is held.
    held_epoch_d = req_hold_q ? held_epoch_q : epoch_q;
    unique case (state_q)
      RUN: begin
        if (redir && (!req_hold_q || bus.req_ready)) begin
          pc_d       = redir_pc;
          epoch_d    = ~epoch_q;
          req_hold_d = 1'b0;
        end else if (redir) begin
          pend_pc_d  = redir_pc;
          epoch_d    = ~epoch_q;
          req_hold_d = 1'b1;
          state_d    = PEND;
        end else if (accept) begin
          pc_d       = npc;
          req_hold_d = 1'b0;
        end else begin
          req_hold_d = req_valid;
        end
      end
      PEND: begin
        if (redir) begin
          pend_pc_d = redir_pc;
          epoch_d   = ~epoch_q;
        end
        if (bus.req_ready) begin
          pc_d       = redir ? redir_pc : pend_pc_q;
          req_hold_d = 1'b0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    req_valid       = !reset && ((state_q == PEND) || !bus.ifq_full || req_hold_q);
    accept          = req_valid && bus.req_ready;
    req.pc          = pc_q;
    req.pair        = dual_issue;
    req.pred_taken  = pred_taken;
    req.pred_target = npc;
    req.epoch       = req_hold_q ? held_epoch_q : epoch_q;
  end

  assign bus.fetch_pc_0      = pc_q;
  assign bus.fetch_pc_1      = fetch_pc_1;
  assign bus.dual_issue      = dual_issue;
  assign bus.req_valid       = req_valid;
  assign bus.req_pc          = req.pc;
  assign bus.req_pair        = req.pair;
  assign bus.req_pred_taken  = req.pred_taken;
  assign bus.req_pred_target = req.pred_target;
  assign bus.req_epoch       = req.epoch;
  assign bus.cur_epoch       = epoch_q;

endmodule

// File: tb/tb_npc_gen.sv
// Directed bench for npc_gen: fall-through, predictor select, held-request
// redirects, flush priority, back-pressure, PC wrap and reset out of PEND.
module tb_npc_gen;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  npc_gen_if bus ();

  npc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run a unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic ready, input logic full,
                               input logic bm, input logic [31:0] target);
    bus.req_ready       = ready;
    bus.ifq_full        = full;
    bus.branch_mistaken = bm;
    bus.right_target    = target;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.flush    = 1'b0;
    bus.flush_pc = 32'h0;
    bus.taken_0  = 1'b0;
    bus.taken_1  = 1'b0;
    bus.ret_pc_0 = 32'h0;
    bus.ret_pc_1 = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    settle();
    checkOutput("valid_in_reset", bus.req_valid, 1'b0);

    // Reset release and sequential fall-through
    reset = 1'b0;
    settle();
    checkOutput("rst_valid", bus.req_valid, 1'b1);
    checkOutput("rst_pc", bus.req_pc, 32'h1c000000);
    checkOutput("rst_pair", bus.req_pair, 1'b1);
    checkOutput("rst_epoch", bus.req_epoch, 1'b0);
    checkOutput("rst_cur_epoch", bus.cur_epoch, 1'b0);
    tick();
    checkOutput("seq_pc1", bus.req_pc, 32'h1c000008);
    tick();
    checkOutput("seq_pc2", bus.req_pc, 32'h1c000010);
    checkOutput("seq_fetch_pc_1", bus.fetch_pc_1, 32'h1c000014);

    // Odd-slot PC: slot-1 prediction must be ignored
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1c000004);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    bus.taken_1  = 1'b1;
    bus.ret_pc_1 = 32'h1c000100;
    settle();
    checkOutput("odd_fetch_pc_0", bus.fetch_pc_0, 32'h1c000004);
    checkOutput("odd_dual", bus.dual_issue, 1'b0);
    checkOutput("odd_pred_taken", bus.req_pred_taken, 2'b00);
    checkOutput("odd_cur_epoch", bus.cur_epoch, 1'b1);
    tick();
    checkOutput("odd_next_pc", bus.req_pc, 32'h1c000008);
    bus.ret_pc_1 = 32'h1c000040;
    settle();
    checkOutput("slot1_dual", bus.dual_issue, 1'b1);
    checkOutput("slot1_pred_taken", bus.req_pred_taken, 2'b10);
    checkOutput("slot1_target", bus.req_pred_target, 32'h1c000040);
    tick();
    checkOutput("slot1_next_pc", bus.req_pc, 32'h1c000040);
    bus.taken_0  = 1'b1;
    bus.ret_pc_0 = 32'h1c000080;
    settle();
    checkOutput("slot0_pred_taken", bus.req_pred_taken, 2'b01);
    checkOutput("slot0_target", bus.req_pred_target, 32'h1c000080);
    tick();
    checkOutput("slot0_next_pc", bus.req_pc, 32'h1c000080);
    bus.taken_0 = 1'b0;
    bus.taken_1 = 1'b0;

    // Mispredict while a request is held goes through PEND
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("hold_issue_pc", bus.req_pc, 32'h1c000000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000200);
    settle();
    checkOutput("hold_redir_pc", bus.req_pc, 32'h1c000000);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("pend_valid_full", bus.req_valid, 1'b1);
    checkOutput("pend_pc", bus.req_pc, 32'h1c000000);
    checkOutput("pend_target", bus.req_pred_target, 32'h1c000008);
    checkOutput("pend_req_epoch", bus.req_epoch, 1'b0);
    checkOutput("pend_cur_epoch", bus.cur_epoch, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("pend_accept_pc", bus.req_pc, 32'h1c000000);
    tick();
    checkOutput("resume_pc", bus.req_pc, 32'h1c000200);
    checkOutput("resume_epoch", bus.req_epoch, 1'b1);

    // Flush beats mispredict in the same cycle
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1c000200);
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h1c001000;
    tick();
    bus.flush = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("flush_pc", bus.req_pc, 32'h1c001000);
    checkOutput("flush_epoch", bus.cur_epoch, 1'b0);

    // Two redirects while PEND: last one wins, epoch toggles twice
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000300);
    tick();
    settle();
    checkOutput("pend2_epoch_a", bus.cur_epoch, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000400);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("pend2_epoch_b", bus.cur_epoch, 1'b0);
    checkOutput("pend2_held_pc", bus.req_pc, 32'h1c001000);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("pend2_resume_pc", bus.req_pc, 32'h1c000400);

    // IF queue full with nothing held blocks the request and the PC
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("full_valid", bus.req_valid, 1'b0);
    tick();
    checkOutput("full_pc_stable", bus.req_pc, 32'h1c000400);

    // Fall-through wraps at the top of the address space
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hfffffff8);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("wrap_target", bus.req_pred_target, 32'h00000000);
    tick();
    checkOutput("wrap_pc", bus.req_pc, 32'h00000000);

    // Reset while PEND drops the parked target
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000300);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000500);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("pre_rst_epoch", bus.cur_epoch, 1'b1);
    reset = 1'b1;
    tick();
    settle();
    checkOutput("midrst_valid", bus.req_valid, 1'b0);
    reset = 1'b0;
    settle();
    checkOutput("postrst_pc", bus.req_pc, 32'h1c000000);
    checkOutput("postrst_epoch", bus.cur_epoch, 1'b0);
    checkOutput("postrst_valid", bus.req_valid, 1'b1);
    tick();
    checkOutput("postrst_next_pc", bus.req_pc, 32'h1c000008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
